float_to_int: RTL

Multi-cycle converter from IEEE-754 single precision to signed 32-bit two's-complement integer, truncating toward zero. It is the return path for `float_adder` results: it consumes the same 32-bit float format and reports exceptions with the same 2-bit `overflow` encoding (00 normal, 01 overflow, 10 underflow, 11 NaN/invalid). Magnitude alignment uses an iterative one-bit-per-cycle shifter driven by a small FSM, so latency depends on the exponent.

---
 rtl/float_to_int.sv | 131 +++++++++++++
 1 files changed

// File: rtl/float_to_int.sv
// IEEE-754 single precision to signed 32-bit integer converter, truncating toward zero.
// Alignment is done by a one-bit-per-cycle shifter, so latency depends on the exponent.
module float_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] z,
    output logic [1:0]  overflow
);

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, SIGN} state_e;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] z_q, z_d;
    logic [1:0]  ovf_q, ovf_d;

    logic        s_q, s_d;
    logic [7:0]  e_q, e_d;
    logic [22:0] m_q, m_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic        left_q, left_d;

    always_comb begin
        // NOTE: every signal gets a default here, so no path through the case can infer a latch.
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        ovf_d   = ovf_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        acc_d   = acc_q;
        count_d = count_q;
        left_d  = left_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = x[31];
                    e_d     = x[30:23];
                    m_d     = x[22:0];
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (e_q == 8'hFF && m_q != 23'd0) begin
                    z_d   = INT_MIN;
                    ovf_d = 2'b11;
                end else if ({s_q, e_q, m_q} == 32'hCF00_0000) begin
                    z_d   = INT_MIN;
                    ovf_d = 2'b00;
                end else if (e_q >= 8'd158) begin
                    z_d   = s_q ? INT_MIN : INT_MAX;
                    ovf_d = 2'b01;
                end else if (e_q == 8'd0 && m_q == 23'd0) begin
                    z_d   = 32'd0;
                    ovf_d = 2'b00;
                end else if (e_q < 8'd127) begin
                    z_d   = 32'd0;
                    ovf_d = 2'b10;
                end else begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    acc_d  = {8'b0, 1'b1, m_q};
                    left_d = (e_q > 8'd150);
                    // |e-150| is at most 23 here, so 5-bit modular arithmetic on e[4:0] is exact.
                    count_d = (e_q < 8'd150) ? (5'd22 - e_q[4:0]) : (e_q[4:0] - 5'd22);
                    state_d = (count_d == 5'd0) ? SIGN : SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = left_q ? (acc_q << 1) : (acc_q >> 1);
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) state_d = SIGN;
            end
            SIGN: begin
                z_d     = s_q ? -acc_q : acc_q;
                ovf_d   = 2'b00;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 32'd0;
            ovf_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: operand and shifter registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        s_q     <= s_d;
        e_q     <= e_d;
        m_q     <= m_d;
        acc_q   <= acc_d;
        count_q <= count_d;
        left_q  <= left_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign z        = z_q;
    assign overflow = ovf_q;

endmodule
